// File: rtl/alu_pkg.sv
// Shared ALU encodings and defaults for the ALU arbitration slice.
// Revision 1.0
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CTRL_WIDTH    = 2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    REQ_ID0 = 1'b0,
    REQ_ID1 = 1'b1
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer names the favoured requester on conflict.
// Revision 1.0
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // After a grant the other requester becomes favoured, so steady contenders alternate.
  always_ff @(posedge clk) begin
    if (reset)         r_ptr <= 1'b0;
    else if (|gnt)     r_ptr <= ~gnt[1];
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, registers tagged responses and NZCV.
// Revision 1.0
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CTRL_W = CTRL_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req0_flagw,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic              req1_flagw,
  output logic [WIDTH-1:0]  alu_srca,
  output logic [WIDTH-1:0]  alu_srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [3:0]        alu_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [3:0]        rsp_flag,
  output logic [3:0]        flags_q
);

  logic       w_can_issue;
  logic [1:0] w_gnt;
  logic       w_accept;
  req_id_e    w_gnt_id;
  logic       w_gnt_flagw;

  assign w_can_issue = !rsp_valid || rsp_ready;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .enable (w_can_issue && !reset),
    .gnt    (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_accept   = |w_gnt;
  assign w_gnt_id   = w_gnt[1] ? REQ_ID1 : REQ_ID0;

  // Idle ALU inputs are parked at zero to keep the shared datapath quiet.
  always_comb begin
    alu_srca    = '0;
    alu_srcb    = '0;
    alu_ctrl    = '0;
    w_gnt_flagw = 1'b0;
    if (w_gnt[0]) begin
      alu_srca    = req0_a;
      alu_srcb    = req0_b;
      alu_ctrl    = req0_ctrl;
      w_gnt_flagw = req0_flagw;
    end else if (w_gnt[1]) begin
      alu_srca    = req1_a;
      alu_srcb    = req1_b;
      alu_ctrl    = req1_ctrl;
      w_gnt_flagw = req1_flagw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= '0;
      flags_q    <= '0;
    end else if (w_accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= w_gnt_id;
      rsp_result <= alu_result;
      rsp_flag   <= alu_flag;
      if (w_gnt_flagw) flags_q <= alu_flag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire
